seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 116 +++++++++++
 tb/tb_seq_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - two-slot serial pattern generator, MSB-first, with stall and gap-free queueing
module seq_gen #(
  parameter int MAXLEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [MAXLEN-1:0] wr_data,
  input  logic [4:0]        wr_len,
  output logic              wr_ready,
  input  logic              hold,
  output logic              dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] MAXLEN_W = 5'(MAXLEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [MAXLEN-1:0] act_sr;
  logic [4:0]        act_cnt;
  logic [MAXLEN-1:0] pnd_sr;
  logic [4:0]        pnd_cnt;
  logic              pnd_vld;

  logic              act_vld;
  logic              accept;
  logic [4:0]        eff_len;
  logic [4:0]        shamt;
  logic [MAXLEN-1:0] wr_aligned;
  logic              advance;
  logic              last;
  logic              act_free;
  logic              to_act;
  logic              to_pnd;
  logic              act_vld_nxt;
  logic              pnd_vld_nxt;

  assign wr_ready = ~pnd_vld;

  // Words are left-aligned on load so the next bit is always the slot's MSB.
  always_comb begin
    act_vld     = (state == SHIFT);
    accept      = wr_en & ~pnd_vld;
    eff_len     = (wr_len > MAXLEN_W) ? MAXLEN_W : wr_len;
    shamt       = MAXLEN_W - eff_len;
    wr_aligned  = wr_data << shamt;
    advance     = act_vld & ~hold;
    last        = advance & (act_cnt == 5'd1);
    act_free    = ~act_vld | last;
    to_act      = accept & (eff_len != 5'd0) & act_free;
    to_pnd      = accept & (eff_len != 5'd0) & ~act_free;
    act_vld_nxt = (act_vld & ~last) | (last & pnd_vld) | to_act;
    pnd_vld_nxt = (pnd_vld & ~last) | to_pnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      act_sr   <= '0;
      act_cnt  <= '0;
      pnd_sr   <= '0;
      pnd_cnt  <= '0;
      pnd_vld  <= 1'b0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dout_vld <= advance;
      done     <= last;
      busy     <= act_vld_nxt | pnd_vld_nxt;
      if (advance) begin
        dout    <= act_sr[MAXLEN-1];
        act_sr  <= act_sr << 1;
        act_cnt <= act_cnt - 5'd1;
      end

      case (state)
        IDLE: begin
          if (to_act) begin
            act_sr  <= wr_aligned;
            act_cnt <= eff_len;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            // Reloading on the last-bit edge keeps the next word's first bit adjacent.
            if (pnd_vld) begin
              act_sr  <= pnd_sr;
              act_cnt <= pnd_cnt;
              pnd_vld <= 1'b0;
            end else if (to_act) begin
              act_sr  <= wr_aligned;
              act_cnt <= eff_len;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (to_pnd) begin
        pnd_sr  <= wr_aligned;
        pnd_cnt <= eff_len;
        pnd_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen
module tb_seq_gen;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [4:0]  wr_len;
  logic        wr_ready;
  logic        hold;
  logic        dout;
  logic        dout_vld;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  seq_gen #(.MAXLEN(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_len   (wr_len),
    .wr_ready (wr_ready),
    .hold     (hold),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dout, dout_vld, done, busy, wr_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state got %b want 00001", {dout, dout_vld, done, busy, wr_ready});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    exp = 8'hB5;
    wr_en = 1'b1; wr_data = 16'h00B5; wr_len = 5'd8;
    tick();
    wr_en = 1'b0;
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency vld=%b busy=%b want vld=0 busy=1", dout_vld, busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp[7-i] || done !== (i == 7)) begin
        errors++;
        $display("FAIL basic_bit%0d vld=%b dout=%b done=%b want 1 %b %b", i, dout_vld, dout, done, exp[7-i], (i == 7));
      end
    end
    tick();
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_end vld=%b busy=%b done=%b want 0 0 0", dout_vld, busy, done);
    end
  endtask

  task automatic test_pair();
    logic [4:0] exp;
    logic [4:0] expd;
    exp  = 5'b10101;
    expd = 5'b00101;
    wr_en = 1'b1; wr_data = 16'h0005; wr_len = 5'd3;
    tick();
    wr_data = 16'h0001; wr_len = 5'd2;
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL pair_pending_full wr_ready=%b want 0", wr_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp[4-i] || done !== expd[4-i]) begin
        errors++;
        $display("FAIL pair_bit%0d vld=%b dout=%b done=%b want 1 %b %b", i, dout_vld, dout, done, exp[4-i], expd[4-i]);
      end
    end
    tick();
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pair_end vld=%b busy=%b want 0 0", dout_vld, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wdat [3];
    logic [4:0]  wlen [3];
    logic [8:0]  exp;
    logic [8:0]  got;
    int widx, nbits, ndone, stalls, first, lastc;
    wdat[0] = 16'h000C; wlen[0] = 5'd4;
    wdat[1] = 16'h0002; wlen[1] = 5'd2;
    wdat[2] = 16'h0003; wlen[2] = 5'd3;
    exp = 9'b110010011;
    got = '0;
    widx = 0; nbits = 0; ndone = 0; stalls = 0; first = -1; lastc = -1;
    for (int c = 0; c < 30; c++) begin
      if (dout_vld === 1'b1) begin
        if (nbits < 9) got[8-nbits] = dout;
        nbits++;
        if (first < 0) first = c;
        lastc = c;
      end
      if (done === 1'b1) ndone++;
      if (widx < 3 && wr_ready === 1'b1) begin
        wr_en = 1'b1; wr_data = wdat[widx]; wr_len = wlen[widx];
        widx++;
      end else begin
        if (widx < 3) stalls++;
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (stalls == 0) begin
      errors++;
      $display("FAIL b2b_stall stalls=%0d want >0", stalls);
    end
    checks++;
    if (nbits != 9 || got !== exp) begin
      errors++;
      $display("FAIL b2b_bits n=%0d got %b want n=9 %b", nbits, got, exp);
    end
    checks++;
    if (ndone != 3 || (lastc - first + 1) != 9) begin
      errors++;
      $display("FAIL b2b_gapfree done=%0d span=%0d want 3 9", ndone, lastc - first + 1);
    end
  endtask

  task automatic test_hold();
    logic [4:0] exp;
    logic [4:0] expd;
    exp  = 5'b01001;
    expd = 5'b00011;
    wr_en = 1'b1; wr_data = 16'h0034; wr_len = 5'd6;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 1'b1) begin
      errors++;
      $display("FAIL hold_bit2 vld=%b dout=%b want 1 1", dout_vld, dout);
    end
    hold = 1'b1;
    wr_en = 1'b1; wr_data = 16'h0001; wr_len = 5'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (dout_vld !== 1'b0 || dout !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d vld=%b dout=%b busy=%b rdy=%b want 0 1 1 0", i, dout_vld, dout, busy, wr_ready);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dout_vld !== 1'b1 || dout !== exp[4-i] || done !== expd[4-i]) begin
        errors++;
        $display("FAIL hold_resume%0d vld=%b dout=%b done=%b want 1 %b %b", i, dout_vld, dout, done, exp[4-i], expd[4-i]);
      end
    end
    tick();
  endtask

  task automatic test_len_edge();
    int nvld, nones, ndone;
    wr_en = 1'b1; wr_data = 16'hFFFF; wr_len = 5'd0;
    tick();
    wr_en = 1'b0;
    nvld = 0; ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dout_vld === 1'b1) nvld++;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (nvld != 0 || ndone != 0) begin
      errors++;
      $display("FAIL len0 vld=%0d done_or_busy=%0d want 0 0", nvld, ndone);
    end
    wr_en = 1'b1; wr_data = 16'hFFFF; wr_len = 5'd20;
    tick();
    wr_en = 1'b0;
    nvld = 0; nones = 0; ndone = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (dout_vld === 1'b1) begin
        nvld++;
        if (dout === 1'b1) nones++;
      end
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (nvld != 16 || nones != 16 || ndone != 1) begin
      errors++;
      $display("FAIL len_clamp vld=%0d ones=%0d done=%0d want 16 16 1", nvld, nones, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int nvld;
    wr_en = 1'b1; wr_data = 16'h03FF; wr_len = 5'd10;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_bit4 vld=%b dout=%b want 1 1", dout_vld, dout);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_vld, done, busy, wr_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_clear got %b want 00001", {dout, dout_vld, done, busy, wr_ready});
    end
    tick();
    rst_n = 1'b1;
    nvld = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dout_vld === 1'b1 || done === 1'b1 || busy === 1'b1) nvld++;
    end
    checks++;
    if (nvld != 0) begin
      errors++;
      $display("FAIL rstmid_quiet active_cycles=%0d want 0", nvld);
    end
    wr_en = 1'b1; wr_data = 16'h0002; wr_len = 5'd2;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_new0 vld=%b dout=%b done=%b want 1 1 0", dout_vld, dout, done);
    end
    tick();
    checks++;
    if (dout_vld !== 1'b1 || dout !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_new1 vld=%b dout=%b done=%b want 1 0 1", dout_vld, dout, done);
    end
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_len  = '0;
    hold    = 1'b0;
    test_reset();
    test_basic();
    test_pair();
    test_back_to_back();
    test_hold();
    test_len_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
